// File: rtl/adc_seq_pkg.sv
// -----------------------------------------------------------------------------
// adc_seq_pkg
// Shared types and default widths for the ADC capture sequencer.
//   seq_state_e   : run-control state encoding (also exported on state_o)
//   *_W_DEF       : default widths for burst count, holdoff and arm timeout
// -----------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int BURST_W_DEF = 16;
    localparam int HOLD_W_DEF  = 16;
    localparam int TMO_W_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

endpackage

// File: rtl/adc_seq_down_counter.sv
// -----------------------------------------------------------------------------
// adc_seq_down_counter
// Loadable down-counter that stops at zero.
//   aclk, aresetn : clock, asynchronous active-low reset
//   load          : load load_val (wins over en)
//   en            : decrement by one while non-zero
//   load_val      : value loaded on load
//   zero          : count is zero
// -----------------------------------------------------------------------------
module adc_seq_down_counter #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_r;

    // Count register: load has priority, decrement stops at zero.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_r <= {W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (en && (count_r != {W{1'b0}})) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/adc_capture_sequencer.sv
// -----------------------------------------------------------------------------
// adc_capture_sequencer
// Run-control FSM for the ADC trigger/capture datapath. Captures cfg_bursts
// triggered bursts, holding the datapath trigger cleared for cfg_holdoff
// cycles between bursts, and reports progress to software.
// Optional feature macro: ADC_SEQ_TIMEOUT_EN adds cfg_timeout, the arm
// timeout counter and the ARMED->DONE timeout exit; without it timed_out
// stays 0 and ARMED waits indefinitely.
// Ports:
//   aclk, aresetn            : clock, asynchronous active-low reset
//   cmd_start, cmd_abort     : software run control (abort wins)
//   cfg_bursts/holdoff/timeout : run config, latched at start
//   adc_trigger_activated    : datapath trigger flag
//   adc_tvalid, adc_tlast    : datapath stream; tvalid&&tlast ends a burst
//   adc_reset_trigger        : active-low trigger clear to the datapath
//   adc_reset_max_sum        : active-high max-sum clear (first CLEAR only)
//   busy, done, timed_out    : status (done is a one-cycle pulse)
//   bursts_done, state_o     : burst count and state for software/debug
// All outputs are registers, so no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module adc_capture_sequencer
    import adc_seq_pkg::*;
#(
    parameter int BURST_W = BURST_W_DEF,
    parameter int HOLD_W  = HOLD_W_DEF
`ifdef ADC_SEQ_TIMEOUT_EN
    , parameter int TMO_W = TMO_W_DEF
`endif
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [BURST_W-1:0] cfg_bursts,
    input  logic [HOLD_W-1:0]  cfg_holdoff,
`ifdef ADC_SEQ_TIMEOUT_EN
    input  logic [TMO_W-1:0]   cfg_timeout,
`endif
    input  logic               adc_trigger_activated,
    input  logic               adc_tvalid,
    input  logic               adc_tlast,
    output logic               adc_reset_trigger,
    output logic               adc_reset_max_sum,
    output logic               busy,
    output logic               done,
    output logic               timed_out,
    output logic [BURST_W-1:0] bursts_done,
    output logic [2:0]         state_o
);

    seq_state_e         state_r;
    seq_state_e         next_state_s;
    seq_state_e         burst_dest_s;
    logic [BURST_W-1:0] target_r;
    logic [HOLD_W-1:0]  holdoff_r;
    logic [BURST_W-1:0] bursts_done_r;
    logic [BURST_W-1:0] bursts_next_s;
    logic [BURST_W-1:0] bursts_inc_s;
    logic               timed_out_r;
    logic               timed_out_next_s;
    logic               latch_s;
    logic               burst_end_s;
    logic               hold_load_s;
    logic               hold_zero_s;
    logic               tmo_expired_s;
    logic               rst_trig_r;
    logic               max_sum_r;
    logic               busy_r;
    logic               done_r;

    function automatic logic [BURST_W-1:0] sat_inc(input logic [BURST_W-1:0] v);
        return (v == {BURST_W{1'b1}}) ? v : v + BURST_W'(1);
    endfunction

    assign burst_end_s  = adc_tvalid && adc_tlast;
    assign bursts_inc_s = sat_inc(bursts_done_r);
    // Where a burst end leads: finished, straight back to CLEAR, or holdoff.
    assign burst_dest_s = (bursts_inc_s == target_r)        ? ST_DONE  :
                          (holdoff_r == {HOLD_W{1'b0}})     ? ST_CLEAR : ST_HOLDOFF;

    // Holdoff counter loads cfg_holdoff-1 on entry, so HOLDOFF lasts
    // exactly cfg_holdoff cycles (exit taken on the cycle it reads zero).
    assign hold_load_s = (next_state_s == ST_HOLDOFF) && (state_r != ST_HOLDOFF);

    adc_seq_down_counter #(.W(HOLD_W)) u_hold_cnt (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (hold_load_s),
        .en       (state_r == ST_HOLDOFF),
        .load_val (holdoff_r - HOLD_W'(1)),
        .zero     (hold_zero_s)
    );

`ifdef ADC_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cfg_r;
    logic             tmo_zero_s;

    // Timeout counter loads during CLEAR so it reads cfg_timeout on the
    // first ARMED cycle and expires cfg_timeout cycles later.
    adc_seq_down_counter #(.W(TMO_W)) u_tmo_cnt (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (state_r == ST_CLEAR),
        .en       (state_r == ST_ARMED),
        .load_val (tmo_cfg_r),
        .zero     (tmo_zero_s)
    );

    assign tmo_expired_s = (tmo_cfg_r != {TMO_W{1'b0}}) && tmo_zero_s;

    // Timeout config, captured at start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tmo_cfg_r <= {TMO_W{1'b0}};
        end else if (latch_s) begin
            tmo_cfg_r <= cfg_timeout;
        end else begin
            tmo_cfg_r <= tmo_cfg_r;
        end
    end
`else
    assign tmo_expired_s = 1'b0;
`endif

    // Next-state and counter update; abort overrides everything outside IDLE.
    always_comb begin
        next_state_s     = state_r;
        bursts_next_s    = bursts_done_r;
        timed_out_next_s = timed_out_r;
        latch_s          = 1'b0;
        if (cmd_abort && (state_r != ST_IDLE)) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Abort outranks start even while idle.
                    if (cmd_start && !cmd_abort) begin
                        next_state_s     = ST_CLEAR;
                        bursts_next_s    = {BURST_W{1'b0}};
                        timed_out_next_s = 1'b0;
                        latch_s          = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    next_state_s = ST_ARMED;
                end
                ST_ARMED: begin
                    // Burst end first: a 1-sample burst may bring trigger and tlast together.
                    if (burst_end_s) begin
                        bursts_next_s = bursts_inc_s;
                        next_state_s  = burst_dest_s;
                    end else if (adc_trigger_activated) begin
                        next_state_s = ST_CAPTURE;
                    end else if (tmo_expired_s) begin
                        timed_out_next_s = 1'b1;
                        next_state_s     = ST_DONE;
                    end else begin
                        next_state_s = ST_ARMED;
                    end
                end
                ST_CAPTURE: begin
                    if (burst_end_s) begin
                        bursts_next_s = bursts_inc_s;
                        next_state_s  = burst_dest_s;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_zero_s) begin
                        next_state_s = ST_CLEAR;
                    end else begin
                        next_state_s = ST_HOLDOFF;
                    end
                end
                ST_DONE: begin
                    next_state_s = ST_IDLE;
                end
                default: begin
                    next_state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Run config, captured at start; a zero burst target means one burst.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            target_r  <= {BURST_W{1'b0}};
            holdoff_r <= {HOLD_W{1'b0}};
        end else if (latch_s) begin
            target_r  <= (cfg_bursts == {BURST_W{1'b0}}) ? BURST_W'(1) : cfg_bursts;
            holdoff_r <= cfg_holdoff;
        end else begin
            target_r  <= target_r;
            holdoff_r <= holdoff_r;
        end
    end

    // FSM state, status counters and outputs registered from the next state.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r       <= ST_IDLE;
            bursts_done_r <= {BURST_W{1'b0}};
            timed_out_r   <= 1'b0;
            rst_trig_r    <= 1'b0;
            max_sum_r     <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            bursts_done_r <= bursts_next_s;
            timed_out_r   <= timed_out_next_s;
            rst_trig_r    <= (next_state_s == ST_ARMED) || (next_state_s == ST_CAPTURE);
            max_sum_r     <= (next_state_s == ST_CLEAR) && (bursts_next_s == {BURST_W{1'b0}});
            busy_r        <= (next_state_s != ST_IDLE);
            done_r        <= (next_state_s == ST_DONE);
        end
    end

    assign adc_reset_trigger = rst_trig_r;
    assign adc_reset_max_sum = max_sum_r;
    assign busy              = busy_r;
    assign done              = done_r;
    assign timed_out         = timed_out_r;
    assign bursts_done       = bursts_done_r;
    assign state_o           = state_r;

endmodule
